// File: rtl/mem_stage_hs.sv
// RISC-V memory stage: issues loads/stores over a req/gnt/rvalid handshake,
// aligns and extends load data, and owns the MEM/WB register.
//
// state  | meaning
// S_IDLE | ready for a new EX/MEM bundle
// S_REQ  | dm_req held, waiting for dm_gnt
// S_RESP | load granted, waiting for dm_rvalid
module mem_stage_hs #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_addr,
  input  logic                in_mem_en,
  input  logic                in_mem_rw,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [2:0]          in_funct3,
  input  logic                in_regwen,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic [1:0]          in_wbsel,
  input  logic                flush,
  output logic                dm_req,
  output logic                dm_we,
  output logic [XLEN-1:0]     dm_addr,
  output logic [XLEN/8-1:0]   dm_be,
  output logic [XLEN-1:0]     dm_wdata,
  input  logic                dm_gnt,
  input  logic                dm_rvalid,
  input  logic [XLEN-1:0]     dm_rdata,
  output logic                wb_valid,
  output logic [XLEN-1:0]     wb_pc4,
  output logic [XLEN-1:0]     wb_alu,
  output logic [XLEN-1:0]     wb_rdata,
  output logic [REG_AW-1:0]   wb_rd,
  output logic                wb_regwen,
  output logic [1:0]          wb_wbsel,
  output logic                wb_misalign
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  state_t state_q, state_d;

  logic              accept, acc_bad, f3_illegal, f3_misalign;
  logic [OB-1:0]     off, off_q;
  logic [NB-1:0]     size_mask, be_d;
  logic [XLEN-1:0]   wdata_d, rdata_sh, load_data;
  logic              issue, retire_now, retire_mem, req_clr, kill_set;
  logic [XLEN-1:0]   pc_q, addr_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        wbsel_q;
  logic [2:0]        f3_q;
  logic              regwen_q, rw_q, kill_q, wb_regwen_q;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign off      = in_addr[OB-1:0];

  always_comb begin
    f3_illegal = (in_funct3 == 3'b111);
    if (XLEN == 32 && (in_funct3 == 3'b011 || in_funct3 == 3'b110)) f3_illegal = 1'b1;
    case (in_funct3[1:0])
      2'b00:   f3_misalign = 1'b0;
      2'b01:   f3_misalign = off[0];
      2'b10:   f3_misalign = |off[1:0];
      default: f3_misalign = |off;
    endcase
    acc_bad = f3_illegal | f3_misalign;
  end

  // Byte enables and lane-replicated store data for the accepting bundle
  always_comb begin
    case (in_funct3[1:0])
      2'b00:   size_mask = NB'(1);
      2'b01:   size_mask = NB'(3);
      2'b10:   size_mask = NB'(15);
      default: size_mask = '1;
    endcase
    be_d    = size_mask << off;
    wdata_d = '0;
    for (int i = 0; i < NB; i++) begin
      case (in_funct3[1:0])
        2'b00:   wdata_d[8*i +: 8] = in_wdata[7:0];
        2'b01:   wdata_d[8*i +: 8] = in_wdata[8*(i%2) +: 8];
        2'b10:   wdata_d[8*i +: 8] = in_wdata[8*(i%4) +: 8];
        default: wdata_d[8*i +: 8] = in_wdata[8*i +: 8];
      endcase
    end
  end

  assign rdata_sh = dm_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = XLEN'($signed(rdata_sh[7:0]));
      3'b001:  load_data = XLEN'($signed(rdata_sh[15:0]));
      3'b010:  load_data = XLEN'($signed(rdata_sh[31:0]));
      3'b011:  load_data = rdata_sh;
      3'b100:  load_data = XLEN'(rdata_sh[7:0]);
      3'b101:  load_data = XLEN'(rdata_sh[15:0]);
      3'b110:  load_data = XLEN'(rdata_sh[31:0]);
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A flush during a granted load is remembered so its response is drained silently
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    retire_now = 1'b0;
    retire_mem = 1'b0;
    req_clr    = 1'b0;
    kill_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_mem_en && !acc_bad) begin
            issue   = 1'b1;
            state_d = S_REQ;
          end else begin
            retire_now = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dm_gnt) begin
          req_clr = 1'b1;
          if (rw_q) begin
            retire_mem = ~flush;
            state_d    = S_IDLE;
          end else begin
            kill_set = flush;
            state_d  = S_RESP;
          end
        end else if (flush) begin
          req_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (dm_rvalid) begin
          retire_mem = ~(flush | kill_q);
          state_d    = S_IDLE;
        end else begin
          kill_set = flush;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_be       <= '0;
      dm_wdata    <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      rd_q        <= '0;
      wbsel_q     <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      regwen_q    <= 1'b0;
      rw_q        <= 1'b0;
      kill_q      <= 1'b0;
      wb_valid    <= 1'b0;
      wb_pc4      <= '0;
      wb_alu      <= '0;
      wb_rdata    <= '0;
      wb_rd       <= '0;
      wb_regwen_q <= 1'b0;
      wb_wbsel    <= '0;
      wb_misalign <= 1'b0;
    end else begin
      wb_valid <= retire_now | retire_mem;
      if (issue) begin
        dm_req   <= 1'b1;
        dm_we    <= in_mem_rw;
        dm_addr  <= {in_addr[XLEN-1:OB], {OB{1'b0}}};
        dm_be    <= be_d;
        dm_wdata <= wdata_d;
        pc_q     <= in_pc;
        addr_q   <= in_addr;
        rd_q     <= in_rd;
        wbsel_q  <= in_wbsel;
        f3_q     <= in_funct3;
        off_q    <= off;
        regwen_q <= in_regwen;
        rw_q     <= in_mem_rw;
      end else if (req_clr) begin
        dm_req   <= 1'b0;
        dm_we    <= 1'b0;
        dm_addr  <= '0;
        dm_be    <= '0;
        dm_wdata <= '0;
      end
      if (issue)         kill_q <= 1'b0;
      else if (kill_set) kill_q <= 1'b1;
      if (retire_now) begin
        wb_pc4      <= in_pc + XLEN'(4);
        wb_alu      <= in_addr;
        wb_rdata    <= '0;
        wb_rd       <= in_rd;
        wb_regwen_q <= in_regwen;
        wb_wbsel    <= in_wbsel;
        wb_misalign <= in_mem_en & acc_bad;
      end else if (retire_mem) begin
        wb_pc4      <= pc_q + XLEN'(4);
        wb_alu      <= addr_q;
        wb_rdata    <= rw_q ? '0 : load_data;
        wb_rd       <= rd_q;
        wb_regwen_q <= regwen_q;
        wb_wbsel    <= wbsel_q;
        wb_misalign <= 1'b0;
      end
    end
  end

  assign wb_regwen = wb_regwen_q & wb_valid & ~wb_misalign;

endmodule
